// File: rtl/mod_counter.sv
// Parametrised modulo counter with prescaler, up/down, load/clear and wrap-or-saturate.
// Optional compare output (cmp_val/match) is enabled by defining MOD_COUNTER_CMP_EN.
module mod_counter #(
  parameter int unsigned     WIDTH    = 16,
  parameter longint unsigned MAX_VAL  = 64'hFFFF,
  parameter int unsigned     PRESCALE = 1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_CMP_EN
  input  logic [WIDTH-1:0] cmp_val,
  output logic             match,
`endif
  output logic [WIDTH-1:0] num,
  output logic             ovf
);

  localparam int unsigned       PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0]  MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);

  // Reject parameter sets that cannot be represented.
  generate
    if (WIDTH == 0 || WIDTH > 64) begin : g_bad_width
      $error("mod_counter: WIDTH must be in 1..64");
    end
    if (WIDTH < 64 && MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
      $error("mod_counter: MAX_VAL must be below 2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_pre
      $error("mod_counter: PRESCALE must be at least 1");
    end
  endgenerate

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] pre_d;
  logic [WIDTH-1:0] num_d;
  logic             ovf_d;

  // Next-state: clear > load > enabled prescale/step; reset lives in the register.
  always_comb begin
    num_d = num;
    pre_d = pre_cnt;
    ovf_d = 1'b0;
    if (clear) begin
      num_d = '0;
      pre_d = '0;
    end else if (load) begin
      num_d = (load_val > MAX_W) ? MAX_W : load_val;
      pre_d = '0;
    end else if (en) begin
      if (pre_cnt != PRE_LAST) begin
        pre_d = pre_cnt + PRE_W'(1);
      end else begin
        pre_d = '0;
        if (up_down) begin
          if (num == MAX_W) begin
            ovf_d = 1'b1;
            if (!SATURATE) num_d = '0;
          end else begin
            num_d = num + WIDTH'(1);
          end
        end else begin
          if (num == '0) begin
            ovf_d = 1'b1;
            if (!SATURATE) num_d = MAX_W;
          end else begin
            num_d = num - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num     <= '0;
      pre_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      num     <= num_d;
      pre_cnt <= pre_d;
      ovf     <= ovf_d;
    end
  end

`ifdef MOD_COUNTER_CMP_EN
  // Compare against the next count so match lines up with num.
  always_ff @(posedge clk) begin
    if (reset) begin
      match <= 1'b0;
    end else begin
      match <= (num_d == cmp_val);
    end
  end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Randomised bench for mod_counter: four parameter sets share stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_mod_counter;

  logic        clk = 1'b0;
  logic        reset, en, up_down, clear, load;
  logic [15:0] load_val;
  logic [15:0] cmp_val;
  logic [15:0] num_a;
  logic [7:0]  num_b, num_c, num_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;
  logic        match_a, match_b, match_c, match_d;

  int total = 0;
  int bad   = 0;

  localparam int MAXV  [4] = '{65535, 9, 9, 9};
  localparam int PREV  [4] = '{1, 1, 1, 4};
  localparam int SATV  [4] = '{0, 0, 1, 0};
  localparam int LVMASK[4] = '{65535, 255, 255, 255};

  int m_num[4];
  int m_pre[4];
  int m_ovf[4];
  int obs_num[4];
  int obs_ovf[4];
  int obs_match[4];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(16), .MAX_VAL(64'hFFFF), .PRESCALE(1), .SATURATE(1'b0)) u_a (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear), .load(load),
    .load_val(load_val),
`ifdef MOD_COUNTER_CMP_EN
    .cmp_val(cmp_val), .match(match_a),
`endif
    .num(num_a), .ovf(ovf_a));

  mod_counter #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b0)) u_b (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear), .load(load),
    .load_val(load_val[7:0]),
`ifdef MOD_COUNTER_CMP_EN
    .cmp_val(cmp_val[7:0]), .match(match_b),
`endif
    .num(num_b), .ovf(ovf_b));

  mod_counter #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b1)) u_c (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear), .load(load),
    .load_val(load_val[7:0]),
`ifdef MOD_COUNTER_CMP_EN
    .cmp_val(cmp_val[7:0]), .match(match_c),
`endif
    .num(num_c), .ovf(ovf_c));

  mod_counter #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(4), .SATURATE(1'b0)) u_d (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear), .load(load),
    .load_val(load_val[7:0]),
`ifdef MOD_COUNTER_CMP_EN
    .cmp_val(cmp_val[7:0]), .match(match_d),
`endif
    .num(num_d), .ovf(ovf_d));

`ifndef MOD_COUNTER_CMP_EN
  assign match_a = 1'b0;
  assign match_b = 1'b0;
  assign match_c = 1'b0;
  assign match_d = 1'b0;
`endif

  assign obs_num[0] = int'(num_a);
  assign obs_num[1] = int'(num_b);
  assign obs_num[2] = int'(num_c);
  assign obs_num[3] = int'(num_d);
  assign obs_ovf[0] = int'(ovf_a);
  assign obs_ovf[1] = int'(ovf_b);
  assign obs_ovf[2] = int'(ovf_c);
  assign obs_ovf[3] = int'(ovf_d);
  assign obs_match[0] = int'(match_a);
  assign obs_match[1] = int'(match_b);
  assign obs_match[2] = int'(match_c);
  assign obs_match[3] = int'(match_d);

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: count space is the ring 0..MAX, stepped every PRESCALE enabled cycles.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int modn;
      modn = MAXV[i] + 1;
      m_ovf[i] = 0;
      if (reset || clear) begin
        m_num[i] = 0;
        m_pre[i] = 0;
      end else if (load) begin
        m_num[i] = (int'(load_val) & LVMASK[i]);
        if (m_num[i] > MAXV[i]) m_num[i] = MAXV[i];
        m_pre[i] = 0;
      end else if (en) begin
        m_pre[i] = m_pre[i] + 1;
        if (m_pre[i] == PREV[i]) begin
          m_pre[i] = 0;
          if (up_down) begin
            m_ovf[i] = (m_num[i] == MAXV[i]) ? 1 : 0;
            if (!(m_ovf[i] == 1 && SATV[i] == 1)) m_num[i] = (m_num[i] + 1) % modn;
          end else begin
            m_ovf[i] = (m_num[i] == 0) ? 1 : 0;
            if (!(m_ovf[i] == 1 && SATV[i] == 1)) m_num[i] = (m_num[i] + modn - 1) % modn;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic c, input logic l, input logic e,
                       input logic u, input logic [15:0] lv);
    reset = r; clear = c; load = l; en = e; up_down = u; load_val = lv;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("num%0d", i), obs_num[i], m_num[i]);
      check($sformatf("ovf%0d", i), obs_ovf[i], m_ovf[i]);
`ifdef MOD_COUNTER_CMP_EN
      check($sformatf("match%0d", i), obs_match[i],
            (m_num[i] == (int'(cmp_val) & LVMASK[i])) ? 1 : 0);
`endif
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b1; up_down = 1'b1;
    load_val = '0; cmp_val = 16'd5;
    for (int i = 0; i < 4; i++) begin
      m_num[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
    end

    // Reset for 5 cycles, last one also asserting load.
    for (int k = 0; k < 5; k++) cycle(1, 0, (k == 4), 1, 1, 16'd7);
    check("rst_num", obs_num[0], 0);
    check("rst_ovf", obs_ovf[0], 0);
    check("rst_load_num", obs_num[1], 0);

    for (int k = 1; k <= 5; k++) begin
      cycle(0, 0, 0, 1, 1, 16'd0);
      check("free_cnt", obs_num[0], k);
    end

    // Modulo-10 wrap up, then down through zero.
    cycle(0, 1, 0, 0, 1, 16'd0);
    for (int k = 1; k <= 10; k++) begin
      cycle(0, 0, 0, 1, 1, 16'd0);
`ifdef MOD_COUNTER_CMP_EN
      check("cmp_seq", obs_match[1], (k == 5) ? 1 : 0);
`endif
    end
    check("wrap_num", obs_num[1], 0);
    check("wrap_ovf", obs_ovf[1], 1);
    check("sat_hold", obs_num[2], 9);
    cycle(0, 0, 0, 1, 1, 16'd0);
    check("wrap_ovf_drop", obs_ovf[1], 0);
    cycle(0, 1, 0, 0, 1, 16'd0);
    cycle(0, 0, 0, 1, 0, 16'd0);
    check("down_wrap_num", obs_num[1], 9);
    check("down_wrap_ovf", obs_ovf[1], 1);
    check("down_sat_num", obs_num[2], 0);
    check("down_sat_ovf", obs_ovf[2], 1);

    // Saturate at top pulses ovf each step.
    cycle(0, 0, 1, 1, 1, 16'd9);
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 0, 1, 1, 16'd0);
      check("sat_top_num", obs_num[2], 9);
      check("sat_top_ovf", obs_ovf[2], 1);
    end

    // Prescale 4 with a 3-cycle enable gap delays the step by 3.
    cycle(0, 1, 0, 0, 1, 16'd0);
    for (int k = 1; k <= 7; k++) begin
      cycle(0, 0, 0, !(k >= 3 && k <= 5), 1, 16'd0);
      if (k == 6) check("pre_before", obs_num[3], 0);
    end
    check("pre_step", obs_num[3], 1);

    // Load / clear / reset priority.
    cycle(0, 0, 1, 1, 1, 16'd7);
    check("load7", obs_num[1], 7);
    cycle(0, 0, 1, 0, 1, 16'd200);
    check("load_clamp", obs_num[1], 9);
    check("load_wide", obs_num[0], 200);
    cycle(0, 1, 1, 1, 1, 16'd7);
    check("clr_over_load", obs_num[1], 0);
    cycle(0, 0, 1, 0, 1, 16'd5);
`ifdef MOD_COUNTER_CMP_EN
    check("cmp_load", obs_match[1], 1);
`endif
    cycle(1, 0, 1, 1, 1, 16'd7);
    check("rst_over_load", obs_num[1], 0);

    // Natural rollover at 2**16-1.
    cycle(0, 0, 1, 0, 1, 16'hFFFF);
    cycle(0, 0, 0, 1, 1, 16'd0);
    check("roll_num", obs_num[0], 0);
    check("roll_ovf", obs_ovf[0], 1);

    // Random traffic with direction held in runs to reach both boundaries.
    begin
      logic dir;
      dir = 1'b1;
      for (int k = 0; k < 3000; k++) begin
        logic [15:0] lv;
        if ($urandom_range(0, 15) == 0) dir = ~dir;
        if (k % 200 == 0) cmp_val = 16'($urandom_range(0, 9));
        lv = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
        cycle(($urandom_range(0, 127) == 0), ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), dir, lv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
